apb_ram_responder: RTL

APB3 completer (responder) that gives the CoreABC-style APB initiator byte-wide access to a 128x8 scratch RAM plus a small control/status register set. It includes an auto-incrementing pointer/data port for block transfers. It has a wait-state engine, because RAM reads use a registered address and therefore need a configurable number of PREADY-low cycles. It sits on the fabric APB segment as one slot behind the controller.

---
 rtl/apb_ram_responder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/apb_ram_responder.sv
// APB3 completer: 128x8 scratch RAM, CTRL/STATUS/PTR registers and an
// auto-incrementing DATA port, with a configurable read wait-state engine.
module apb_ram_responder #(
  parameter int DEPTH           = 128,
  parameter int RD_WAIT         = 1,
  parameter bit ERR_ON_UNMAPPED = 1'b1
) (
  input  logic       PCLK,
  input  logic       RESET,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  output logic       IRQ
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e        state_q;
  logic [1:0]    cnt_q;
  logic          ie_q, ainc_q, wrap_q;
  logic [AW-1:0] ptr_q, raddr_q;
  logic [7:0]    prdata_q;
  logic          pready_q, pslverr_q;
  logic [7:0]    mem [DEPTH];

  logic          setup, access, commit, ram_we, slow_rd, unmapped;
  logic          hit_ram, hit_ctrl, hit_stat, hit_ptr, hit_data;
  logic [AW-1:0] ptr_inc_d, ram_addr_d;
  logic [7:0]    reg_rd_d;

  assign setup    = PSEL & ~PENABLE;
  assign access   = PSEL & PENABLE;
  assign hit_ram  = {1'b0, PADDR} < 9'(DEPTH);
  assign hit_ctrl = PADDR == 8'h80;
  assign hit_stat = PADDR == 8'h81;
  assign hit_ptr  = PADDR == 8'h82;
  assign hit_data = PADDR == 8'h83;
  assign unmapped = ~(hit_ram | hit_ctrl | hit_stat | hit_ptr | hit_data);
  assign slow_rd  = ~PWRITE & (hit_ram | hit_data);

  // Side effects land on the edge that closes the PREADY=1 access cycle.
  assign commit     = (state_q == S_DONE) & access & ~RESET;
  assign ram_addr_d = hit_data ? ptr_q : PADDR[AW-1:0];
  assign ram_we     = commit & PWRITE & (hit_ram | hit_data);
  assign ptr_inc_d  = ptr_q + AW'(1);

  always_comb begin
    reg_rd_d = 8'h00;
    if (hit_ctrl) reg_rd_d = {6'b0, ainc_q, ie_q};
    if (hit_stat) reg_rd_d = {7'b0, wrap_q};
    if (hit_ptr)  reg_rd_d = 8'(ptr_q);
  end

  // Decoding on the setup phase lets the registered PREADY be high in the
  // first access cycle (zero waits) or after exactly RD_WAIT low cycles.
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= 2'd0;
      ie_q      <= 1'b0;
      ainc_q    <= 1'b0;
      wrap_q    <= 1'b0;
      ptr_q     <= '0;
      raddr_q   <= '0;
      prdata_q  <= 8'h00;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (setup) begin
          if (slow_rd) begin
            raddr_q <= ram_addr_d;
            cnt_q   <= 2'd1;
            state_q <= S_WAIT;
          end else begin
            pready_q  <= 1'b1;
            pslverr_q <= unmapped & ERR_ON_UNMAPPED;
            if (!PWRITE) prdata_q <= reg_rd_d;
            state_q   <= S_DONE;
          end
        end
        S_WAIT: begin
          if (!access) begin
            state_q <= S_IDLE;
          end else if (cnt_q == 2'(RD_WAIT)) begin
            pready_q  <= 1'b1;
            pslverr_q <= 1'b0;
            prdata_q  <= mem[raddr_q];
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        S_DONE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          state_q   <= S_IDLE;
          if (commit) begin
            if (PWRITE && hit_ctrl) {ainc_q, ie_q} <= PWDATA[1:0];
            if (PWRITE && hit_stat && PWDATA[0]) wrap_q <= 1'b0;
            if (PWRITE && hit_ptr) ptr_q <= PWDATA[AW-1:0];
            if (hit_data && ainc_q) begin
              ptr_q <= ptr_inc_d;
              if (ptr_q == AW'(DEPTH - 1)) wrap_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (ram_we) mem[ram_addr_d] <= PWDATA;
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign IRQ     = wrap_q & ie_q;
endmodule
